// File: rtl/cpu_pkg.sv
// Shared cpu constants and fetch-unit types.
// Imported by the fetch unit, its interface and program memory.
package cpu_pkg;

    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [INST_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    function automatic logic [INST_W-1:0] word_align(
        input logic [INST_W-1:0] a
    );
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Control, program-load and instruction bundle between
// the cpu (master) and the fetch unit (slave).
interface inst_fetch_if #(
    parameter int ADDR_W = 6
);
    import cpu_pkg::*;

    logic              start;
    logic              stall;
    logic              redirect;
    logic [INST_W-1:0] redirect_pc;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [INST_W-1:0] prog_data;
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] inst_pc;
    logic              inst_valid;
    logic              busy;
    logic              done;
    logic              prog_err;

    modport master (
        output start, stall, redirect, redirect_pc,
        output prog_we, prog_addr, prog_data,
        input  inst, inst_pc, inst_valid,
        input  busy, done, prog_err
    );

    modport slave (
        input  start, stall, redirect, redirect_pc,
        input  prog_we, prog_addr, prog_data,
        output inst, inst_pc, inst_valid,
        output busy, done, prog_err
    );

endinterface

// File: rtl/inst_fetch_prog_mem.sv
// Program store: one write port, combinational read.
// Contents survive reset.
module prog_mem
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [INST_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [INST_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch.sv
// Self-sequencing instruction fetch: program memory, pc,
// stall/redirect handling and halt detection.
module inst_fetch #(
    parameter int ADDR_W = 6,
    parameter logic [31:0] HALT_WORD = cpu_pkg::HALT_WORD,
    parameter logic [31:0] NOP_WORD  = cpu_pkg::NOP_WORD
) (
    input  logic         clk,
    input  logic         reset,
    inst_fetch_if.slave  bus
);
    import cpu_pkg::*;

    fetch_state_t state, state_n;

    logic [INST_W-1:0] pc, pc_n;
    logic [INST_W-1:0] inst_q, inst_n;
    logic [INST_W-1:0] ipc_q, ipc_n;
    logic              valid_q, valid_n;
    logic              err_q, err_n;
    logic [INST_W-1:0] rd;
    logic              beyond;
    logic              mem_we;

    // Running off the end of memory and redirecting past it
    // both surface here as upper pc bits being set.
    assign beyond = |pc[INST_W-1:ADDR_W+2];
    assign mem_we = bus.prog_we && (state != RUN);

    prog_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_data),
        .raddr (pc[ADDR_W+1:2]),
        .rdata (rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc      <= '0;
            inst_q  <= NOP_WORD;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            inst_q  <= inst_n;
            ipc_q   <= ipc_n;
            valid_q <= valid_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        inst_n  = inst_q;
        ipc_n   = ipc_q;
        valid_n = valid_q;
        err_n   = err_q;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = RUN;
                    pc_n    = '0;
                end
            end
            RUN: begin
                if (bus.prog_we) begin
                    err_n = 1'b1;
                end
                if (bus.redirect) begin
                    pc_n    = word_align(bus.redirect_pc);
                    inst_n  = NOP_WORD;
                    valid_n = 1'b0;
                end else if (!bus.stall) begin
                    if (beyond || rd == HALT_WORD) begin
                        state_n = DONE;
                        inst_n  = NOP_WORD;
                        valid_n = 1'b0;
                    end else begin
                        inst_n  = rd;
                        ipc_n   = pc;
                        valid_n = 1'b1;
                        pc_n    = pc + 32'd4;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.inst       = inst_q;
    assign bus.inst_pc    = ipc_q;
    assign bus.inst_valid = valid_q;
    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.prog_err   = err_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a random
// run, checked against a program-level reference model.
module tb_inst_fetch;
    import cpu_pkg::*;

    localparam int AW    = 6;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(AW)) bif ();
    inst_fetch_if #(.ADDR_W(2))  sif ();

    inst_fetch #(.ADDR_W(AW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    inst_fetch #(.ADDR_W(2)) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    int total = 0;
    int bad   = 0;

    // reference model: 0 idle, 1 running, 2 finished
    int          m_st;
    logic [31:0] m_pc, m_inst, m_ipc;
    logic        m_valid, m_err;
    logic [31:0] m_mem [DEPTH];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st    = 0;
        m_pc    = 0;
        m_inst  = NOP_WORD;
        m_ipc   = 0;
        m_valid = 0;
        m_err   = 0;
    endtask

    task automatic model_halt();
        m_st    = 2;
        m_inst  = NOP_WORD;
        m_valid = 0;
    endtask

    task automatic model_edge();
        logic [31:0] w;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_st == 1) begin
            if (bif.prog_we) m_err = 1;
            if (bif.redirect) begin
                m_pc    = bif.redirect_pc & 32'hFFFF_FFFC;
                m_inst  = NOP_WORD;
                m_valid = 0;
            end else if (!bif.stall) begin
                if (m_pc >= 32'(4 * DEPTH)) begin
                    model_halt();
                end else begin
                    w = m_mem[m_pc[AW+1:2]];
                    if (w == HALT_WORD) begin
                        model_halt();
                    end else begin
                        m_inst  = w;
                        m_ipc   = m_pc;
                        m_valid = 1;
                        m_pc    = m_pc + 4;
                    end
                end
            end
        end else begin
            if (bif.prog_we) m_mem[bif.prog_addr] = bif.prog_data;
            if (bif.start) begin
                m_st = 1;
                m_pc = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("inst", bif.inst, m_inst);
        chk("inst_pc", bif.inst_pc, m_ipc);
        chk("valid", {31'b0, bif.inst_valid}, {31'b0, m_valid});
        chk("busy", {31'b0, bif.busy}, {31'b0, m_st == 1});
        chk("done", {31'b0, bif.done}, {31'b0, m_st == 2});
        chk("prog_err", {31'b0, bif.prog_err}, {31'b0, m_err});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bif.prog_we   = 1;
        bif.prog_addr = AW'(a);
        bif.prog_data = d;
        step();
        bif.prog_we   = 0;
    endtask

    task automatic go();
        bif.start = 1;
        step();
        bif.start = 0;
    endtask

    task automatic run_to_done(input int lim);
        int n;
        n = 0;
        while (m_st == 1 && n < lim) begin
            step();
            n++;
        end
        chk("run_done", {31'b0, bif.done}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1;
        bif.start       = 0;
        bif.stall       = 0;
        bif.redirect    = 0;
        bif.redirect_pc = 0;
        bif.prog_we     = 0;
        bif.prog_addr   = 0;
        bif.prog_data   = 0;
        sif.start       = 0;
        sif.stall       = 0;
        sif.redirect    = 0;
        sif.redirect_pc = 0;
        sif.prog_we     = 0;
        sif.prog_addr   = 0;
        sif.prog_data   = 0;
        model_reset();
        #2;
        step();
        step();
        chk("rst_inst", bif.inst, NOP_WORD);
        chk("rst_done", {31'b0, bif.done}, 32'd0);
        reset = 0;

        for (int i = 0; i < DEPTH; i++) wr(i, 32'h0000_1000 + i);
        wr(0, 32'h2001_0001);
        wr(1, 32'h2002_0001);
        wr(2, HALT_WORD);
        wr(4, 32'h0022_1020);
        wr(5, 32'h0043_1820);
        wr(6, HALT_WORD);

        // basic run to the halt sentinel
        go();
        chk("t1_busy", {31'b0, bif.busy}, 32'd1);
        step();
        chk("t1_i0", bif.inst, 32'h2001_0001);
        chk("t1_pc0", bif.inst_pc, 32'h0);
        step();
        chk("t1_i1", bif.inst, 32'h2002_0001);
        chk("t1_pc1", bif.inst_pc, 32'h4);
        step();
        chk("t1_done", {31'b0, bif.done}, 32'd1);
        chk("t1_nv", {31'b0, bif.inst_valid}, 32'd0);

        // stall held three cycles
        go();
        step();
        bif.stall = 1;
        repeat (3) begin
            step();
            chk("t2_hold", bif.inst, 32'h2001_0001);
            chk("t2_hpc", bif.inst_pc, 32'h0);
        end
        bif.stall = 0;
        step();
        chk("t2_next", bif.inst, 32'h2002_0001);
        run_to_done(10);

        // redirect with a bubble, low bits ignored
        go();
        step();
        bif.redirect    = 1;
        bif.redirect_pc = 32'h13;
        step();
        chk("t3_bub", {31'b0, bif.inst_valid}, 32'd0);
        bif.redirect = 0;
        step();
        chk("t3_tgt", bif.inst, 32'h0022_1020);
        chk("t3_tpc", bif.inst_pc, 32'h10);
        run_to_done(10);

        // redirect wins over stall
        go();
        step();
        bif.redirect    = 1;
        bif.stall       = 1;
        bif.redirect_pc = 32'h10;
        step();
        bif.redirect = 0;
        bif.stall    = 0;
        step();
        chk("t4_tgt", bif.inst, 32'h0022_1020);
        run_to_done(10);

        // redirect on the edge that would fetch the halt word
        go();
        step();
        step();
        bif.redirect    = 1;
        bif.redirect_pc = 32'h14;
        step();
        chk("t5_nodone", {31'b0, bif.done}, 32'd0);
        bif.redirect = 0;
        step();
        chk("t5_tgt", bif.inst, 32'h0043_1820);
        chk("t5_tpc", bif.inst_pc, 32'h14);
        run_to_done(10);

        // program write during a run is refused
        go();
        step();
        bif.prog_we   = 1;
        bif.prog_addr = 0;
        bif.prog_data = 32'hDEAD_BEEF;
        step();
        bif.prog_we = 0;
        chk("t6_err", {31'b0, bif.prog_err}, 32'd1);
        run_to_done(10);
        go();
        step();
        chk("t6_mem", bif.inst, 32'h2001_0001);
        step();
        // asynchronous reset in the middle of a run
        #2;
        reset = 1;
        #1;
        model_reset();
        check_all();
        chk("t6_rerr", {31'b0, bif.prog_err}, 32'd0);
        chk("t6_rinst", bif.inst, NOP_WORD);
        step();
        reset = 0;
        go();
        step();
        chk("t6_again", bif.inst, 32'h2001_0001);
        run_to_done(10);

        // redirect past the end of memory
        go();
        step();
        bif.redirect    = 1;
        bif.redirect_pc = 32'h400;
        step();
        bif.redirect = 0;
        step();
        chk("t7_done", {31'b0, bif.done}, 32'd1);
        chk("t7_nv", {31'b0, bif.inst_valid}, 32'd0);

        // four-word memory with no halt word: no wrap
        for (int i = 0; i < 4; i++) begin
            sif.prog_we   = 1;
            sif.prog_addr = 2'(i);
            sif.prog_data = 32'h1111_0000 + i;
            step();
        end
        sif.prog_we = 0;
        sif.start   = 1;
        step();
        sif.start = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t8_pc", sif.inst_pc, 32'(4 * k));
            chk("t8_inst", sif.inst, 32'h1111_0000 + k);
            chk("t8_v", {31'b0, sif.inst_valid}, 32'd1);
        end
        step();
        chk("t8_done", {31'b0, sif.done}, 32'd1);
        chk("t8_nv", {31'b0, sif.inst_valid}, 32'd0);
        step();
        chk("t8_hold", sif.inst_pc, 32'hC);
        chk("t8_busy", {31'b0, sif.busy}, 32'd0);

        // random program and random control traffic
        for (int i = 0; i < DEPTH; i++) begin
            wr(i, ($urandom_range(0, 19) == 0) ? HALT_WORD : $urandom);
        end
        for (int c = 0; c < 3000; c++) begin
            bif.start    = 0;
            bif.stall    = 0;
            bif.redirect = 0;
            bif.prog_we  = 0;
            if (m_st != 1) begin
                bif.start = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0) begin
                    bif.prog_we   = 1;
                    bif.prog_addr = AW'($urandom);
                    bif.prog_data = ($urandom_range(0, 9) == 0)
                                    ? HALT_WORD : $urandom;
                end
            end else begin
                bif.start    = ($urandom_range(0, 9) == 0);
                bif.stall    = ($urandom_range(0, 4) == 0);
                bif.redirect = ($urandom_range(0, 11) == 0);
                bif.redirect_pc = ($urandom_range(0, 7) == 0)
                                  ? $urandom
                                  : 32'($urandom_range(0, 4 * DEPTH - 1));
                bif.prog_we   = ($urandom_range(0, 49) == 0);
                bif.prog_addr = AW'($urandom);
                bif.prog_data = $urandom;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
